// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the single-port memory side of the data-memory arbiter.
// slave = arbiter view, master = requesters plus memory.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the CPU (port 0)
// and the debug/loader port (port 1); fixed-latency reads, one read outstanding.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LAT);

  state_t            r_state;
  logic [2:0]        r_lat_cnt;
  logic              r_owner;
  logic              r_last_winner;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  logic [1:0]        w_req;
  logic [1:0]        w_we;
  logic [1:0]        w_gnt;
  logic [1:0]        w_rvalid;
  logic [ADDR_W-1:0] w_addr  [2];
  logic [DATA_W-1:0] w_wdata [2];
  logic              w_rd_done;
  logic              w_issue_ok;
  logic              w_grant;
  logic              w_win;

  assign w_req      = {bus.req1, bus.req0};
  assign w_we       = {bus.we1, bus.we0};
  assign w_addr[0]  = bus.addr0;
  assign w_addr[1]  = bus.addr1;
  assign w_wdata[0] = bus.wdata0;
  assign w_wdata[1] = bus.wdata1;

  // A completing read frees the memory in its own return cycle, so reads pipeline.
  assign w_rd_done  = !rst && (r_state == ST_RD_WAIT) && (r_lat_cnt == 3'd1);
  assign w_issue_ok = !rst && ((r_state == ST_IDLE) || w_rd_done);
  assign w_win      = (w_req == 2'b11) ? ~r_last_winner : w_req[1];
  assign w_grant    = w_issue_ok && (w_req != 2'b00);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign w_gnt[gi]    = w_grant && (w_win == 1'(gi));
      assign w_rvalid[gi] = w_rd_done && (r_owner == 1'(gi));
    end
  endgenerate

  assign bus.gnt0      = w_gnt[0];
  assign bus.gnt1      = w_gnt[1];
  assign bus.rvalid0   = w_rvalid[0];
  assign bus.rvalid1   = w_rvalid[1];
  assign bus.rdata     = bus.mem_rdata;
  assign bus.mem_en    = w_grant;
  assign bus.mem_we    = w_grant && w_we[w_win];
  // Address and write data hold their last driven value between accesses.
  assign bus.mem_addr  = w_grant ? w_addr[w_win]  : r_addr;
  assign bus.mem_wdata = w_grant ? w_wdata[w_win] : r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_lat_cnt     <= 3'd0;
      r_owner       <= 1'b0;
      r_last_winner <= 1'b1;
      r_addr        <= '0;
      r_wdata       <= '0;
    end else begin
      if (r_state == ST_RD_WAIT) begin
        r_lat_cnt <= r_lat_cnt - 3'd1;
        if (r_lat_cnt == 3'd1) begin
          r_state <= ST_IDLE;
        end
      end
      if (w_grant) begin
        r_last_winner <= w_win;
        r_addr        <= w_addr[w_win];
        r_wdata       <= w_wdata[w_win];
        if (!w_we[w_win]) begin
          r_owner   <= w_win;
          r_lat_cnt <= LAT_INIT;
          r_state   <= ST_RD_WAIT;
        end
      end
    end
  end

endmodule
